// File: rtl/text_line_buffer.sv
// text_line_buffer: single-line text buffer feeding a VGA character renderer.
// Printable ASCII is appended at the cursor. Backspace erases the last cell.
// Form-feed blanks the whole line, one cell per cycle. All other codes are
// accepted and dropped.
// Optional feature: define CURSOR_BLINK_EN to overlay a blinking '_' at the
// cursor position. The blink period is set by BLINK_BITS.
module text_line_buffer #(
  parameter int LEN        = 41,
  parameter int BLINK_BITS = 23
) (
  input  logic                  clk25,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_char,
  output logic                  wr_ready,
  output logic [0:LEN-1][0:7]   char,
  output logic [5:0]            cursor,
  output logic                  full,
  output logic                  overflow
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [5:0] LEN_C      = 6'(LEN);
  localparam logic [5:0] LAST_C     = 6'(LEN - 1);
  localparam logic [7:0] CODE_BS    = 8'd8;
  localparam logic [7:0] CODE_FF    = 8'd12;
  localparam logic [7:0] CODE_FIRST = 8'd32;
  localparam logic [7:0] CODE_LAST  = 8'd126;
  localparam logic [7:0] BLANK      = 8'd0;

  state_t               state;
  state_t               state_next;
  logic [0:LEN-1][0:7]  cells;
  logic [5:0]           clr_idx;
  logic                 accept;
  logic                 printable;

  assign accept    = wr_valid && wr_ready;
  assign printable = (wr_char >= CODE_FIRST) && (wr_char <= CODE_LAST);
  assign full      = (cursor == LEN_C);

  // State register; reset wins over everything, including an active clear.
  always_ff @(posedge clk25) begin
    // NOTE: clocked state always uses non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic: form-feed starts a clear, the last cell write ends it.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (accept && (wr_char == CODE_FF)) state_next = CLEAR;
      CLEAR:   if (clr_idx == LAST_C)              state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: the buffer can take a character only while not clearing.
  always_comb begin
    wr_ready = (state == IDLE);
  end

  // Buffer contents, cursor, clear index and overflow pulse.
  always_ff @(posedge clk25) begin
    if (!rst) begin
      // NOTE: the cell array is a flop bank, not a RAM, so it can and must
      // be wiped in the single reset cycle.
      cells    <= '0;
      cursor   <= '0;
      clr_idx  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (state == CLEAR) begin
        cells[clr_idx] <= BLANK;
        clr_idx        <= clr_idx + 6'd1;
      end else if (accept) begin
        if (printable) begin
          if (cursor < LEN_C) begin
            cells[cursor] <= wr_char;
            cursor        <= cursor + 6'd1;
          end else begin
            // Line is full: drop the character and flag it, never wrap.
            overflow <= 1'b1;
          end
        end else if (wr_char == CODE_BS) begin
          if (cursor != 6'd0) begin
            cells[cursor - 6'd1] <= BLANK;
            cursor               <= cursor - 6'd1;
          end
        end else if (wr_char == CODE_FF) begin
          cursor  <= '0;
          clr_idx <= '0;
        end
      end
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam logic [7:0] UNDERSCORE = 8'd95;

  logic [BLINK_BITS-1:0] blink_cnt;

  // Free-running blink timer; its MSB is the cursor visibility phase.
  always_ff @(posedge clk25) begin
    if (!rst) blink_cnt <= '0;
    else      blink_cnt <= blink_cnt + 1'b1;
  end

  // Overlay '_' at the cursor during the on phase; stored cells untouched.
  always_comb begin
    char = cells;
    if (blink_cnt[BLINK_BITS-1] && (cursor < LEN_C)) char[cursor] = UNDERSCORE;
  end
`else
  assign char = cells;
`endif

endmodule
